branch_train_queue: RTL and testbench

- In-order queue of in-flight gshare predictions.
- Captures pc, history and predicted direction for every prediction issued.
- When the branch resolves, pops the oldest entry and drives the gshare predictor's training port: train_valid, train_taken, train_mispredicted, train_history, train_pc.
- On a misprediction it squashes every younger (wrong-path) entry.

---
 rtl/branch_train_queue.sv | 140 ++++++++++++++
 tb/tb_branch_train_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_train_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_train_queue
// Purpose  : In-order queue of in-flight gshare predictions. Pops on resolve
//            and drives the predictor training port. Optional statistics
//            counters are enabled by BRANCH_TRAIN_QUEUE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_train_queue #(
    parameter int N     = 7,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       pred_valid,
    input  logic [N-1:0]               pred_pc,
    input  logic                       pred_taken,
    input  logic [N-1:0]               pred_history,
    output logic                       pred_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       train_valid,
    output logic                       train_taken,
    output logic                       train_mispredicted,
    output logic [N-1:0]               train_history,
    output logic [N-1:0]               train_pc,
    output logic [$clog2(DEPTH):0]     count,
`ifdef BRANCH_TRAIN_QUEUE_STATS_EN
    output logic [15:0]                stat_resolved,
    output logic [15:0]                stat_mispredicted,
`endif
    output logic                       resolve_error
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(DEPTH);

    logic [N-1:0]          r_pc_mem   [DEPTH];
    logic [N-1:0]          r_hist_mem [DEPTH];
    logic                  r_taken_mem[DEPTH];

    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_train_valid;
    logic                  r_train_taken;
    logic                  r_train_mis;
    logic [N-1:0]          r_train_hist;
    logic [N-1:0]          r_train_pc;
    logic                  r_resolve_error;

    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_mis;
    logic                  w_flush;
    logic                  w_push_keep;

    assign w_ready     = (r_count != c_FULL);
    assign w_push      = pred_valid && w_ready;
    assign w_pop       = resolve_valid && (r_count != '0);
    assign w_mis       = resolve_taken ^ r_taken_mem[r_head];
    assign w_flush     = w_pop && w_mis;
    // A push alongside a flush is itself wrong-path and must not be kept.
    assign w_push_keep = w_push && !w_flush;

    always_ff @(posedge clk) begin
        if (w_push_keep) begin
            r_pc_mem[r_tail]    <= pred_pc;
            r_hist_mem[r_tail]  <= pred_history;
            r_taken_mem[r_tail] <= pred_taken;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push_keep) r_tail <= r_tail + c_PTR_W'(1);
            if (w_pop)       r_head <= r_head + c_PTR_W'(1);
            if (w_push_keep && !w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (w_pop && !w_push_keep) r_count <= r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_train_valid   <= 1'b0;
            r_train_taken   <= 1'b0;
            r_train_mis     <= 1'b0;
            r_train_hist    <= '0;
            r_train_pc      <= '0;
            r_resolve_error <= 1'b0;
        end else begin
            r_train_valid <= w_pop;
            if (w_pop) begin
                r_train_taken <= resolve_taken;
                r_train_mis   <= w_mis;
                r_train_hist  <= r_hist_mem[r_head];
                r_train_pc    <= r_pc_mem[r_head];
            end
            if (resolve_valid && (r_count == '0)) r_resolve_error <= 1'b1;
        end
    end

`ifdef BRANCH_TRAIN_QUEUE_STATS_EN
    logic [15:0] r_stat_resolved;
    logic [15:0] r_stat_mis;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_stat_resolved <= '0;
            r_stat_mis      <= '0;
        end else if (w_pop) begin
            if (r_stat_resolved != 16'hFFFF) r_stat_resolved <= r_stat_resolved + 16'd1;
            if (w_mis && (r_stat_mis != 16'hFFFF)) r_stat_mis <= r_stat_mis + 16'd1;
        end
    end

    assign stat_resolved     = r_stat_resolved;
    assign stat_mispredicted = r_stat_mis;
`endif

    assign pred_ready         = w_ready;
    assign train_valid        = r_train_valid;
    assign train_taken        = r_train_taken;
    assign train_mispredicted = r_train_mis;
    assign train_history      = r_train_hist;
    assign train_pc           = r_train_pc;
    assign count              = r_count;
    assign resolve_error      = r_resolve_error;

endmodule
`default_nettype wire

// File: tb/tb_branch_train_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_train_queue
// Purpose  : Self-checking bench for branch_train_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_train_queue;

    localparam int N     = 7;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          areset;
    logic          pred_valid;
    logic [N-1:0]  pred_pc;
    logic          pred_taken;
    logic [N-1:0]  pred_history;
    logic          pred_ready;
    logic          resolve_valid;
    logic          resolve_taken;
    logic          train_valid;
    logic          train_taken;
    logic          train_mispredicted;
    logic [N-1:0]  train_history;
    logic [N-1:0]  train_pc;
    logic [CW-1:0] count;
    logic          resolve_error;
`ifdef BRANCH_TRAIN_QUEUE_STATS_EN
    logic [15:0]   stat_resolved;
    logic [15:0]   stat_mispredicted;
    int            m_res;
    int            m_mis;
`endif

    always #5 clk = ~clk;

    branch_train_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .areset             (areset),
        .pred_valid         (pred_valid),
        .pred_pc            (pred_pc),
        .pred_taken         (pred_taken),
        .pred_history       (pred_history),
        .pred_ready         (pred_ready),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_history      (train_history),
        .train_pc           (train_pc),
        .count              (count),
`ifdef BRANCH_TRAIN_QUEUE_STATS_EN
        .stat_resolved      (stat_resolved),
        .stat_mispredicted  (stat_mispredicted),
`endif
        .resolve_error      (resolve_error)
    );

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] hist;
        logic         taken;
    } ent_t;

    ent_t         q[$];
    logic         e_tv, e_tt, e_mis, e_err;
    logic [N-1:0] e_pc, e_h;
    int           n_cmp = 0;
    int           n_mis = 0;
    logic         record = 1'b0;
    logic [N-1:0] got[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        e_tv = 0; e_tt = 0; e_mis = 0; e_err = 0; e_pc = '0; e_h = '0;
`ifdef BRANCH_TRAIN_QUEUE_STATS_EN
        m_res = 0; m_mis = 0;
`endif
    endtask

    task automatic check_all();
        check("train_valid", 32'(train_valid), 32'(e_tv));
        check("train_taken", 32'(train_taken), 32'(e_tt));
        check("train_mispredicted", 32'(train_mispredicted), 32'(e_mis));
        check("train_pc", 32'(train_pc), 32'(e_pc));
        check("train_history", 32'(train_history), 32'(e_h));
        check("count", 32'(count), 32'(q.size()));
        check("pred_ready", 32'(pred_ready), 32'(q.size() != DEPTH));
        check("resolve_error", 32'(resolve_error), 32'(e_err));
`ifdef BRANCH_TRAIN_QUEUE_STATS_EN
        check("stat_resolved", 32'(stat_resolved), 32'(m_res));
        check("stat_mispredicted", 32'(stat_mispredicted), 32'(m_mis));
`endif
    endtask

    // One clock: drive inputs, advance the model, compare just after the edge.
    task automatic cyc(input logic pv, input logic [N-1:0] pc, input logic [N-1:0] h,
                       input logic pt, input logic rv, input logic rt);
        ent_t e;
        logic push;
        pred_valid = pv; pred_pc = pc; pred_history = h; pred_taken = pt;
        resolve_valid = rv; resolve_taken = rt;
        push = pv && (q.size() != DEPTH);
        e_tv = 1'b0;
        if (rv && q.size() != 0) begin
            e = q[0];
            e_tv = 1'b1; e_tt = rt; e_mis = rt ^ e.taken; e_pc = e.pc; e_h = e.hist;
`ifdef BRANCH_TRAIN_QUEUE_STATS_EN
            if (m_res < 16'hFFFF) m_res++;
            if (e_mis && m_mis < 16'hFFFF) m_mis++;
`endif
            if (e_mis) q.delete();
            else begin
                void'(q.pop_front());
                if (push) q.push_back('{pc: pc, hist: h, taken: pt});
            end
        end else begin
            if (rv) e_err = 1'b1;
            if (push) q.push_back('{pc: pc, hist: h, taken: pt});
        end
        @(posedge clk);
        #1;
        check_all();
        if (record && train_valid) got.push_back(train_pc);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push1(input logic [N-1:0] pc, input logic [N-1:0] h, input logic t);
        cyc(1'b1, pc, h, t, 1'b0, 1'b0);
    endtask

    task automatic pop1(input logic rt);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, rt);
    endtask

    task automatic do_reset();
        areset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b1;
        check_all();
    endtask

    initial begin
        areset = 1'b0;
        pred_valid = 0; pred_pc = '0; pred_taken = 0; pred_history = '0;
        resolve_valid = 0; resolve_taken = 0;
        model_clear();

        // Reset then idle
        do_reset();
        check("reset_count", 32'(count), 32'd0);
        check("reset_ready", 32'(pred_ready), 32'd1);
        idle();

        // Correct prediction path
        push1(7'h12, 7'h05, 1'b1);
        pop1(1'b1);
        check("correct_tv", 32'(train_valid), 32'd1);
        check("correct_mis", 32'(train_mispredicted), 32'd0);
        check("correct_pc", 32'(train_pc), 32'h12);
        check("correct_hist", 32'(train_history), 32'h05);
        check("correct_count", 32'(count), 32'd0);
        idle();

        // Fill and wrap
        record = 1'b1;
        got.delete();
        for (int i = 0; i < 8; i++) push1(7'(i), 7'(i + 32), 1'b1);
        check("full_count", 32'(count), 32'd8);
        check("full_ready", 32'(pred_ready), 32'd0);
        push1(7'h7F, 7'h7F, 1'b1);
        check("drop_count", 32'(count), 32'd8);
        for (int i = 0; i < 3; i++) pop1(1'b1);
        for (int i = 8; i < 11; i++) push1(7'(i), 7'(i + 32), 1'b1);
        for (int i = 0; i < 8; i++) pop1(1'b1);
        record = 1'b0;
        check("wrap_len", 32'(got.size()), 32'd11);
        for (int i = 0; i < 11 && i < got.size(); i++) check("wrap_seq", 32'(got[i]), 32'(i));
        check("wrap_count", 32'(count), 32'd0);

        // Mispredict flush
        push1(7'd1, 7'h11, 1'b0);
        push1(7'd2, 7'h12, 1'b0);
        push1(7'd3, 7'h13, 1'b0);
        cyc(1'b1, 7'd4, 7'h14, 1'b0, 1'b1, 1'b1);
        check("flush_pc", 32'(train_pc), 32'd1);
        check("flush_mis", 32'(train_mispredicted), 32'd1);
        check("flush_count", 32'(count), 32'd0);
        push1(7'd5, 7'h15, 1'b1);
        pop1(1'b1);
        check("after_flush_pc", 32'(train_pc), 32'd5);

        // Simultaneous push and pop
        push1(7'd20, 7'h01, 1'b0);
        push1(7'd21, 7'h02, 1'b1);
        cyc(1'b1, 7'd22, 7'h03, 1'b1, 1'b1, 1'b0);
        check("simul_count", 32'(count), 32'd2);
        check("simul_pc", 32'(train_pc), 32'd20);
        pop1(1'b1);
        check("simul_order1", 32'(train_pc), 32'd21);
        pop1(1'b1);
        check("simul_order2", 32'(train_pc), 32'd22);

        // Underflow then asynchronous reset mid-cycle
        pop1(1'b0);
        check("underflow_err", 32'(resolve_error), 32'd1);
        check("underflow_tv", 32'(train_valid), 32'd0);
        push1(7'd30, 7'h30, 1'b1);
        push1(7'd31, 7'h31, 1'b1);
        push1(7'd32, 7'h32, 1'b1);
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        #2;
        areset = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_err", 32'(resolve_error), 32'd0);
        check("async_ready", 32'(pred_ready), 32'd1);
        model_clear();
        resolve_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        areset = 1'b1;
        repeat (3) idle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic pv, rv, rt;
            pv = ($urandom_range(0, 99) < 60);
            rv = (q.size() != 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
            rt = (q.size() != 0 && $urandom_range(0, 99) < 85) ? q[0].taken : 1'($urandom);
            cyc(pv, 7'($urandom), 7'($urandom), 1'($urandom), rv, rt);
            if (c == 1500) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
